ieeedrv_wrmux: RTL

- Write-side counterpart to the drive ROM read multiplexer.
- Collects single-byte write requests from up to NDR drive CPUs into one shared memory write port. Each drive owns a one-entry holding slot; a round-robin arbiter drains the slots at one write per clock.
- Sits between the per-drive CPU/buffer logic and the shared image/buffer RAM port A.

---
 rtl/ieeedrv_wrmux.sv | 119 +++++++++++
 1 files changed

// File: rtl/ieeedrv_wrmux.sv
// Per-drive one-entry write slots drained round-robin into one memory write port; capture-to-write >= 2 clocks.
// mem_hold stalls grants; a write to a busy slot is dropped (sticky drv_ovf when IEEEDRV_WRMUX_OVF_EN is defined).
module ieeedrv_wrmux #(
   parameter int NDR       = 4,
   parameter int ADDRWIDTH = 14,
   parameter int DATAWIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [NDR-1:0]       i_drv_wr,
   input  logic [ADDRWIDTH-1:0] i_drv_addr [NDR],
   input  logic [DATAWIDTH-1:0] i_drv_data [NDR],
   output logic [NDR-1:0]       o_drv_busy,
   output logic [NDR-1:0]       o_drv_ack,
   output logic [NDR-1:0]       o_drv_ovf,
   input  logic [NDR-1:0]       i_ovf_clr,
   input  logic                 i_mem_hold,
   output logic [ADDRWIDTH-1:0] o_mem_addr,
   output logic [DATAWIDTH-1:0] o_mem_data,
   output logic                 o_mem_wren
);

   logic [NDR-1:0]       r_busy;
   logic [NDR-1:0]       r_ack;
   logic [ADDRWIDTH-1:0] r_slot_addr [NDR];
   logic [DATAWIDTH-1:0] r_slot_data [NDR];
   logic [1:0]           r_rr_ptr;
   logic                 r_wren;
   logic [ADDRWIDTH-1:0] r_mem_addr;
   logic [DATAWIDTH-1:0] r_mem_data;

   logic                 w_gnt_vld;
   logic [1:0]           w_gnt_idx;
   logic [1:0]           w_rr_next;
   int                   w_best_dist;
   int                   w_dist;

   // Winner is the busy slot closest to rr_ptr going upward modulo NDR.
   always_comb begin
      w_gnt_idx   = 2'd0;
      w_best_dist = NDR;
      w_dist      = 0;
      for (int i = 0; i < NDR; i++) begin
         w_dist = (i + NDR - int'(r_rr_ptr)) % NDR;
         if (r_busy[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_gnt_idx   = 2'(i);
         end
      end
      w_gnt_vld = !i_mem_hold && (w_best_dist < NDR);
      w_rr_next = 2'((int'(w_gnt_idx) + 1) % NDR);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_busy     <= '0;
         r_ack      <= '0;
         r_wren     <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_rr_ptr   <= 2'd0;
         for (int i = 0; i < NDR; i++) begin
            r_slot_addr[i] <= '0;
            r_slot_data[i] <= '0;
         end
      end else begin
         r_wren <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_rr_ptr <= w_rr_next;
         end
         for (int i = 0; i < NDR; i++) begin
            r_ack[i] <= w_gnt_vld && (w_gnt_idx == 2'(i));
            if (w_gnt_vld && (w_gnt_idx == 2'(i))) begin
               r_mem_addr <= r_slot_addr[i];
               r_mem_data <= r_slot_data[i];
            end
            // Capture and grant never target the same slot: one needs busy low, the other high.
            if (i_drv_wr[i] && !r_busy[i]) begin
               r_busy[i]      <= 1'b1;
               r_slot_addr[i] <= i_drv_addr[i];
               r_slot_data[i] <= i_drv_data[i];
            end else if (w_gnt_vld && (w_gnt_idx == 2'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

`ifdef IEEEDRV_WRMUX_OVF_EN
   logic [NDR-1:0] r_ovf;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NDR; i++) begin
            if (i_drv_wr[i] && r_busy[i]) begin
               r_ovf[i] <= 1'b1;
            end else if (i_ovf_clr[i]) begin
               r_ovf[i] <= 1'b0;
            end
         end
      end
   end

   assign o_drv_ovf = r_ovf;
`else
   logic w_unused_ovf_clr;
   assign w_unused_ovf_clr = ^i_ovf_clr;
   assign o_drv_ovf        = '0;
`endif

   assign o_drv_busy = r_busy;
   assign o_drv_ack  = r_ack;
   assign o_mem_wren = r_wren;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_data = r_mem_data;

endmodule
